// File: rtl/hcp_pkg.sv
// Shared constants and types for the TDM HCP transmitter.
package hcp_pkg;

    localparam logic [7:0] START_FRAME = 8'h7E;
    localparam logic [7:0] STOP_FRAME  = 8'hFE;
    localparam int         FLAG_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ACK
    } ch_state_t;

    typedef enum logic [1:0] {
        STAT_ACK      = 2'd0,
        STAT_NACK     = 2'd1,
        STAT_UNDERRUN = 2'd2
    } ch_status_t;

endpackage

// File: rtl/hcp_tx_lane.sv
// One HCP channel: holding register, shift register, flag/stuffing sequencer.
// Drive values are registered here and only change on the lane's own slot start,
// so the top-level owner mux only ever selects a stable register.
module hcp_tx_lane
    import hcp_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int STUFF_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              own_slot_start,
    input  logic              own_slot_end,
    input  logic              ack_sample,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              sbda_i,
    output logic              tx_ready,
    output logic              drv_o,
    output logic              drv_oe,
    output logic              done,
    output logic [1:0]        status,
    output logic              busy
);

    localparam int MAXC  = (DATA_W > FLAG_BITS) ? DATA_W : FLAG_BITS;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int RUN_W = $clog2(STUFF_RUN + 1);

    ch_state_t         state_q, state_n;
    logic [DATA_W-1:0] hold_q, hold_n, shift_q, shift_n;
    logic              hold_last_q, hold_last_n, hold_valid_q, hold_valid_n;
    logic              last_q, last_n;
    logic [7:0]        flag_q, flag_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [RUN_W-1:0]  run_q, run_n, run_base;
    logic              underrun_q, underrun_n, nack_q, nack_n;
    logic              drv_o_q, drv_o_n, drv_oe_q, drv_oe_n;
    logic              done_q, done_n;
    logic [1:0]        status_q, status_n;
    logic              load, stop;

    // A reload keeps the 1s run going across the byte boundary; entering DATA from START clears it.
    assign run_base = (state_q == ST_DATA) ? run_q : '0;

    // Next-state: byte capture, ACK sampling, and per-own-slot bit selection.
    always_comb begin
        state_n      = state_q;
        hold_n       = hold_q;
        hold_last_n  = hold_last_q;
        hold_valid_n = hold_valid_q;
        shift_n      = shift_q;
        last_n       = last_q;
        flag_n       = flag_q;
        cnt_n        = cnt_q;
        run_n        = run_q;
        underrun_n   = underrun_q;
        nack_n       = nack_q;
        drv_o_n      = drv_o_q;
        drv_oe_n     = drv_oe_q;
        done_n       = 1'b0;
        status_n     = status_q;
        load         = 1'b0;
        stop         = 1'b0;

        // Ready is the registered !hold_valid, so a reload can never enable a same-edge accept.
        if (tx_valid && !hold_valid_q) begin
            hold_n       = tx_data;
            hold_last_n  = tx_last;
            hold_valid_n = 1'b1;
        end

        if (ack_sample && state_q == ST_ACK)
            nack_n = sbda_i;

        if (own_slot_end && state_q == ST_ACK) begin
            state_n  = ST_IDLE;
            done_n   = 1'b1;
            status_n = underrun_q ? STAT_UNDERRUN : (nack_n ? STAT_NACK : STAT_ACK);
        end

        if (own_slot_start) begin
            drv_o_n  = 1'b0;
            drv_oe_n = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (hold_valid_q) begin
                        state_n    = ST_START;
                        flag_n     = START_FRAME >> 1;
                        cnt_n      = CNT_W'(1);
                        underrun_n = 1'b0;
                        drv_o_n    = START_FRAME[0];
                        drv_oe_n   = 1'b1;
                    end
                end
                ST_START, ST_STOP: begin
                    if (cnt_q == CNT_W'(FLAG_BITS)) begin
                        if (state_q == ST_START) load = 1'b1;
                        else                     state_n = ST_ACK;
                    end else begin
                        drv_o_n  = flag_q[0];
                        drv_oe_n = 1'b1;
                        flag_n   = flag_q >> 1;
                        cnt_n    = cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (run_q == RUN_W'(STUFF_RUN)) begin
                        // Stuffed 0: occupies the slot without consuming a payload bit.
                        drv_oe_n = 1'b1;
                        run_n    = '0;
                    end else if (cnt_q == CNT_W'(DATA_W)) begin
                        if (last_q)            stop = 1'b1;
                        else if (hold_valid_q) load = 1'b1;
                        else begin
                            stop       = 1'b1;
                            underrun_n = 1'b1;
                        end
                    end else begin
                        drv_o_n  = shift_q[0];
                        drv_oe_n = 1'b1;
                        shift_n  = shift_q >> 1;
                        cnt_n    = cnt_q + 1'b1;
                        run_n    = shift_q[0] ? run_q + 1'b1 : '0;
                    end
                end
                default: ;
            endcase

            if (load) begin
                state_n      = ST_DATA;
                shift_n      = hold_q >> 1;
                last_n       = hold_last_q;
                hold_valid_n = 1'b0;
                cnt_n        = CNT_W'(1);
                run_n        = hold_q[0] ? run_base + 1'b1 : '0;
                drv_o_n      = hold_q[0];
                drv_oe_n     = 1'b1;
            end
            if (stop) begin
                state_n  = ST_STOP;
                flag_n   = STOP_FRAME >> 1;
                cnt_n    = CNT_W'(1);
                drv_o_n  = STOP_FRAME[0];
                drv_oe_n = 1'b1;
            end
        end
    end

    // State register; reset aborts any frame and discards the holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            last_q       <= 1'b0;
            flag_q       <= '0;
            cnt_q        <= '0;
            run_q        <= '0;
            underrun_q   <= 1'b0;
            nack_q       <= 1'b0;
            drv_o_q      <= 1'b0;
            drv_oe_q     <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= 2'd0;
        end else begin
            state_q      <= state_n;
            hold_q       <= hold_n;
            hold_last_q  <= hold_last_n;
            hold_valid_q <= hold_valid_n;
            shift_q      <= shift_n;
            last_q       <= last_n;
            flag_q       <= flag_n;
            cnt_q        <= cnt_n;
            run_q        <= run_n;
            underrun_q   <= underrun_n;
            nack_q       <= nack_n;
            drv_o_q      <= drv_o_n;
            drv_oe_q     <= drv_oe_n;
            done_q       <= done_n;
            status_q     <= status_n;
        end
    end

    assign tx_ready = !hold_valid_q;
    assign drv_o    = drv_o_q;
    assign drv_oe   = drv_oe_q;
    assign done     = done_q;
    assign status   = status_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: rtl/hcp_master_tdm.sv
// TDM HCP transmitter: slot counters, one lane per channel, owner mux onto SBDA.
module hcp_master_tdm
    import hcp_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int SLOT_CYC  = 4,
    parameter int STUFF_RUN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        tx_valid,
    input  logic [NUM_CH*DATA_W-1:0] tx_data,
    input  logic [NUM_CH-1:0]        tx_last,
    output logic [NUM_CH-1:0]        tx_ready,
    input  logic                     sbda_i,
    output logic                     sbda_o,
    output logic                     sbda_oe,
    output logic [NUM_CH-1:0]        done,
    output logic [NUM_CH*2-1:0]      status,
    output logic [NUM_CH-1:0]        busy
);

    localparam int CYC_W  = $clog2(SLOT_CYC);
    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CYC_W-1:0]       cyc_cnt;
    logic [SLOT_W-1:0]      slot_idx, slot_nxt;
    logic                   cyc_wrap;
    logic [NUM_CH-1:0]      lane_o, lane_oe;
    logic [NUM_CH-1:0][1:0] lane_status;

    assign cyc_wrap = (cyc_cnt == CYC_W'(SLOT_CYC - 1));
    assign slot_nxt = (slot_idx == SLOT_W'(NUM_CH - 1)) ? '0 : slot_idx + 1'b1;

    // Free-running slot timebase; slot_idx steps when cyc_cnt wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt  <= '0;
            slot_idx <= '0;
        end else if (cyc_wrap) begin
            cyc_cnt  <= '0;
            slot_idx <= slot_nxt;
        end else begin
            cyc_cnt  <= cyc_cnt + 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        hcp_tx_lane #(
            .DATA_W    (DATA_W),
            .STUFF_RUN (STUFF_RUN)
        ) u_lane (
            .clk            (clk),
            .rst_n          (rst_n),
            .own_slot_start (cyc_wrap && (slot_nxt == SLOT_W'(c))),
            .own_slot_end   (cyc_wrap && (slot_idx == SLOT_W'(c))),
            .ack_sample     ((cyc_cnt == CYC_W'(SLOT_CYC / 2)) && (slot_idx == SLOT_W'(c))),
            .tx_valid       (tx_valid[c]),
            .tx_data        (tx_data[c*DATA_W +: DATA_W]),
            .tx_last        (tx_last[c]),
            .sbda_i         (sbda_i),
            .tx_ready       (tx_ready[c]),
            .drv_o          (lane_o[c]),
            .drv_oe         (lane_oe[c]),
            .done           (done[c]),
            .status         (lane_status[c]),
            .busy           (busy[c])
        );
    end

    // Owner mux: lane drive registers already update on their own slot edge.
    assign sbda_o  = lane_o[slot_idx];
    assign sbda_oe = lane_oe[slot_idx];
    assign status  = lane_status;

endmodule

// File: tb/tb_hcp_master_tdm.sv
// Directed bench for hcp_master_tdm (NUM_CH=2, SLOT_CYC=4, 8 cycles per own slot).
module tb_hcp_master_tdm;

    localparam int DATA_W = 8, NUM_CH = 2, SLOT_CYC = 4, STUFF_RUN = 4;
    localparam int P = SLOT_CYC * NUM_CH;

    logic                     clk = 1'b0, rst_n = 1'b0;
    logic [NUM_CH-1:0]        tx_valid = '0, tx_last = '0, tx_ready, done, busy;
    logic [NUM_CH*DATA_W-1:0] tx_data = '0;
    logic [NUM_CH*2-1:0]      status;
    logic                     sbda_i = 1'b1, sbda_o, sbda_oe;

    int total = 0, bad = 0;
    int k = 0;   // posedges since reset release

    string SF = "01111110";   // 0x7E LSB first
    string EF = "01111111";   // 0xFE LSB first

    hcp_master_tdm #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SLOT_CYC(SLOT_CYC), .STUFF_RUN(STUFF_RUN)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(tx_ready), .sbda_i(sbda_i), .sbda_o(sbda_o), .sbda_oe(sbda_oe),
        .done(done), .status(status), .busy(busy));

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else        k <= k + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic wait_k(input int kk);
        int g = 0;
        do begin @(negedge clk); g++; end while (k < kk && g < 10000);
        total++;
        if (k != kk) begin bad++; $display("FAIL sync: at edge %0d, needed edge %0d", k, kk); end
    endtask

    task automatic send(input int c, input logic [7:0] d, input logic l, output int acc);
        tx_valid[c] = 1'b1; tx_data[c*DATA_W +: DATA_W] = d; tx_last[c] = l;
        total++;
        if (tx_ready[c] !== 1'b1) begin bad++; $display("FAIL ready_before ch%0d: got %b need 1", c, tx_ready[c]); end
        @(negedge clk);
        acc = k;
        tx_valid[c] = 1'b0; tx_last[c] = 1'b0;
        total++;
        if (tx_ready[c] !== 1'b0) begin bad++; $display("FAIL ready_after ch%0d: got %b need 0", c, tx_ready[c]); end
    endtask

    task automatic wait_ready(input int c);
        int g = 0;
        while (tx_ready[c] !== 1'b1 && g < 400) begin @(negedge clk); g++; end
        total++;
        if (tx_ready[c] !== 1'b1) begin bad++; $display("FAIL ready_wait ch%0d: got %b need 1", c, tx_ready[c]); end
    endtask

    function automatic int first_bnd(input int c, input int acc);
        int b = acc + 1;
        while ((b % P) != c * SLOT_CYC) b++;
        return b;
    endfunction

    // Checks every own slot of a frame starting at boundary edge b0, then ACK release and done.
    task automatic check_frame(input int c, input int b0, input string bits, input logic [1:0] st, input bit solo);
        int   n = bits.len();
        logic exp_o;
        for (int i = 0; i < n; i++) begin
            wait_k(b0 + P*i + 1);
            exp_o = (bits[i] == "1");
            total++;
            if ({sbda_oe, sbda_o} !== {1'b1, exp_o}) begin
                bad++; $display("FAIL frame ch%0d slot %0d: oe,o=%b%b need 1%b", c, i, sbda_oe, sbda_o, exp_o);
            end
            if (solo) begin
                wait_k(b0 + P*i + SLOT_CYC + 1);
                total++;
                if ({sbda_oe, sbda_o} !== 2'b00) begin
                    bad++; $display("FAIL other_slot ch%0d slot %0d: oe,o=%b%b need 00", c, i, sbda_oe, sbda_o);
                end
            end
        end
        wait_k(b0 + P*n + 1);
        total++;
        if ({sbda_oe, sbda_o, busy[c]} !== 3'b001) begin
            bad++; $display("FAIL ack_slot ch%0d: oe,o,busy=%b%b%b need 001", c, sbda_oe, sbda_o, busy[c]);
        end
        wait_k(b0 + P*n + SLOT_CYC);
        total++;
        if ({done[c], status[c*2 +: 2]} !== {1'b1, st}) begin
            bad++; $display("FAIL done ch%0d: done,status=%b,%0d need 1,%0d", c, done[c], status[c*2 +: 2], st);
        end
        wait_k(b0 + P*n + SLOT_CYC + 1);
        total++;
        if ({done[c], busy[c]} !== 2'b00) begin
            bad++; $display("FAIL done_end ch%0d: done,busy=%b%b need 00", c, done[c], busy[c]);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({sbda_o, sbda_oe, tx_ready, done, status, busy} !== {2'b00, 2'b11, 2'b00, 4'd0, 2'b00}) begin
            bad++; $display("FAIL reset: o,oe=%b%b ready=%b done=%b status=%h busy=%b need 00 11 00 0 00",
                            sbda_o, sbda_oe, tx_ready, done, status, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({sbda_oe, busy} !== 3'b000) begin bad++; $display("FAIL idle_line: oe,busy=%b%b need 000", sbda_oe, busy); end
    endtask

    task automatic test_single();
        int acc;
        sbda_i = 1'b0;
        send(0, 8'h5A, 1'b1, acc);
        check_frame(0, first_bnd(0, acc), {SF, "01011010", EF}, 2'd0, 1'b1);
    endtask

    task automatic test_stuff_nack();
        int acc;
        sbda_i = 1'b1;
        send(0, 8'hFF, 1'b1, acc);
        check_frame(0, first_bnd(0, acc), {SF, "1111011110", EF}, 2'd1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int acc, acc2, b0;
        sbda_i = 1'b0;
        send(1, 8'h0F, 1'b0, acc);
        b0 = first_bnd(1, acc);
        fork
            check_frame(1, b0, {SF, "111100000000011110", EF}, 2'd0, 1'b1);
            begin
                wait_ready(1);
                send(1, 8'hF0, 1'b1, acc2);
            end
        join
    endtask

    task automatic test_underrun();
        int acc;
        sbda_i = 1'b0;
        send(0, 8'h11, 1'b0, acc);
        check_frame(0, first_bnd(0, acc), {SF, "10001000", EF}, 2'd2, 1'b1);
    endtask

    task automatic test_concurrent();
        int acc;
        sbda_i = 1'b0;
        tx_valid = 2'b11; tx_data = {8'h3C, 8'hA5}; tx_last = 2'b11;
        total++;
        if (tx_ready !== 2'b11) begin bad++; $display("FAIL conc_ready: got %b need 11", tx_ready); end
        @(negedge clk);
        acc = k;
        tx_valid = 2'b00; tx_last = 2'b00;
        fork
            check_frame(0, first_bnd(0, acc), {SF, "10100101", EF}, 2'd0, 1'b0);
            check_frame(1, first_bnd(1, acc), {SF, "001111000", EF}, 2'd0, 1'b0);
        join
    endtask

    task automatic test_reset_mid();
        int acc, acc2, b0;
        sbda_i = 1'b0;
        send(0, 8'h5A, 1'b0, acc);
        b0 = first_bnd(0, acc);
        wait_ready(0);
        send(0, 8'h33, 1'b0, acc2);
        wait_k(b0 + P*10 + 1);   // payload bit 2 of 0x5A
        total++;
        if ({sbda_oe, sbda_o} !== 2'b10) begin bad++; $display("FAIL pre_reset: oe,o=%b%b need 10", sbda_oe, sbda_o); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({sbda_o, sbda_oe, tx_ready, done, status, busy} !== {2'b00, 2'b11, 2'b00, 4'd0, 2'b00}) begin
            bad++; $display("FAIL async_reset: o,oe=%b%b ready=%b done=%b status=%h busy=%b need 00 11 00 0 00",
                            sbda_o, sbda_oe, tx_ready, done, status, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3*P) @(negedge clk);
        total++;
        if ({busy, tx_ready, sbda_oe} !== 5'b00110) begin
            bad++; $display("FAIL hold_discard: busy=%b ready=%b oe=%b need 00 11 0", busy, tx_ready, sbda_oe);
        end
        send(0, 8'hA5, 1'b1, acc);
        check_frame(0, first_bnd(0, acc), {SF, "10100101", EF}, 2'd0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stuff_nack();
        test_back_to_back();
        test_underrun();
        test_concurrent();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
